// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation in flight.
// Optional opcode check enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*OP_W-1:0]   req_op,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [DATA_W-1:0]   resp_result,
    output logic                resp_zero,
    output logic                resp_err,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OP_W-1:0]     alu_control,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    output logic                busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1
    // for the same bit; req_ready never depends on req_* of the other requester beyond grant.
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
`ifdef ALU_ARB_OPCHECK_EN
    logic                bad_q, bad_d;
    logic                err_q, err_d;
`endif

    logic                grant;
    logic [DATA_W-1:0]   a_sel;
    logic [DATA_W-1:0]   b_sel;
    logic [OP_W-1:0]     op_sel;

    // On contention the requester that was not served last wins.
    always_comb begin
        grant  = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        a_sel  = grant ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        b_sel  = grant ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        op_sel = grant ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        result_d   = result_q;
        zero_d     = zero_q;
        req_ready  = 2'b00;
`ifdef ALU_ARB_OPCHECK_EN
        bad_d      = bad_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!RESET && (req_valid != 2'b00)) begin
                    req_ready  = grant ? 2'b10 : 2'b01;
                    owner_d    = grant;
                    alu_a_d    = a_sel;
                    alu_b_d    = b_sel;
                    state_d    = EXEC;
`ifdef ALU_ARB_OPCHECK_EN
                    bad_d      = (op_sel >= OP_W'(10));
                    alu_ctrl_d = (op_sel >= OP_W'(10)) ? '0 : op_sel;
`else
                    alu_ctrl_d = op_sel;
`endif
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
                err_d    = bad_q;
                if (bad_q) begin
                    result_d = '0;
                    zero_d   = 1'b1;
                end
`endif
                state_d  = RESP;
            end
            RESP: begin
                if (resp_ready[owner_q]) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            bad_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
`ifdef ALU_ARB_OPCHECK_EN
            bad_q      <= bad_d;
            err_q      <= err_d;
`endif
        end
    end

    assign resp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign busy        = (state_q != IDLE);
`ifdef ALU_ARB_OPCHECK_EN
    assign resp_err    = err_q;
`else
    assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases with literal expectations, then random traffic
// checked every cycle against a transaction-level model. Honours ALU_ARB_OPCHECK_EN.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam int OW = 4;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [2*W-1:0] req_a = '0;
  logic [2*W-1:0] req_b = '0;
  logic [2*OW-1:0] req_op = '0;
  logic [1:0]    resp_valid;
  logic [1:0]    resp_ready = '0;
  logic [W-1:0]  resp_result;
  logic          resp_zero;
  logic          resp_err;
  logic [W-1:0]  alu_a, alu_b;
  logic [OW-1:0] alu_control;
  logic [W-1:0]  alu_result;
  logic          alu_zero;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  alu_arbiter #(.DATA_W(W), .OP_W(OW)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // clock / reset
  always #5 CLOCK = ~CLOCK;

  // ALU behaviour as seen by the arbiter
  function automatic logic [W-1:0] ref_alu(input logic [OW-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return W'($signed(a) >>> b[4:0]);
      4'd8: return (a < b) ? 32'd1 : 32'd0;
      4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_control, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: round-robin pick, preferring whoever was not served last
  function automatic bit pick(input logic [1:0] v, input bit last);
    if (v[!last]) return !last;
    return last;
  endfunction

  bit            m_inflight = 1'b0;
  bit            m_owner = 1'b0;
  int            m_age = 0;
  bit            m_last = 1'b1;
  logic [W-1:0]  m_a = '0, m_b = '0, m_res = '0;
  logic [OW-1:0] m_ctrl = '0;
  bit            m_zero = 1'b0, m_err = 1'b0;
  logic [W+1:0]  exp_q[$];
  int            n_done = 0;
  logic [1:0]    acc_q = '0;

  always @(posedge CLOCK) begin
    bit g;
    logic [OW-1:0] op;
    logic [W-1:0] r;
    bit bad;
    acc_q = req_valid & req_ready;
    if (RESET) begin
      m_inflight = 0; m_last = 1; m_age = 0;
      m_a = '0; m_b = '0; m_ctrl = '0; m_res = '0; m_zero = 0; m_err = 0;
      exp_q.delete();
    end else if (!m_inflight) begin
      if (req_valid != 2'b00) begin
        g = pick(req_valid, m_last);
        m_inflight = 1; m_owner = g; m_age = 1;
        m_a = req_a[g*W +: W];
        m_b = req_b[g*W +: W];
        op  = req_op[g*OW +: OW];
        bad = (op >= 4'd10);
`ifdef ALU_ARB_OPCHECK_EN
        if (bad) begin
          m_ctrl = '0;
          exp_q.push_back({1'b1, 1'b1, 32'd0});
        end else begin
          m_ctrl = op;
          r = ref_alu(op, m_a, m_b);
          exp_q.push_back({1'b0, (r == '0), r});
        end
`else
        m_ctrl = op;
        r = ref_alu(op, m_a, m_b);
        exp_q.push_back({1'b0, (r == '0), r});
`endif
      end
    end else if (m_age == 1) begin
      m_age = 2;
      {m_err, m_zero, m_res} = exp_q[0];
    end else if (resp_ready[m_owner]) begin
      m_inflight = 0;
      m_last = m_owner;
      void'(exp_q.pop_front());
      n_done++;
    end
  end

  // scoreboard compare on every falling edge
  always @(negedge CLOCK) begin
    logic [1:0] exp_rr, exp_rv;
    if (mon_en) begin
      exp_rr = (!RESET && !m_inflight && req_valid != 2'b00) ?
               (pick(req_valid, m_last) ? 2'b10 : 2'b01) : 2'b00;
      exp_rv = (m_inflight && m_age == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("mon_req_ready", req_ready, exp_rr);
      chk("mon_resp_valid", resp_valid, exp_rv);
      chk("mon_busy", busy, m_inflight);
      chk("mon_resp_result", resp_result, m_res);
      chk("mon_resp_zero", resp_zero, m_zero);
      chk("mon_resp_err", resp_err, m_err);
      chk("mon_alu_a", alu_a, m_a);
      chk("mon_alu_b", alu_b, m_b);
      chk("mon_alu_control", alu_control, m_ctrl);
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [OW-1:0] op);
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_op[i*OW +: OW] = op;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    cyc();
    cyc();
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    RESET = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    // 1: ADD 5+7 from requester 0
    do_reset();
    set_req(0, 32'd5, 32'd7, 4'd0);
    req_valid = 2'b01;
    #2 chk("t1_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    #2 chk("t1_busy", busy, 1'b1);
    chk("t1_exec_rv", resp_valid, 2'b00);
    chk("t1_alu_a", alu_a, 32'd5);
    cyc();
    #2 chk("t1_resp_valid", resp_valid, 2'b01);
    chk("t1_result", resp_result, 32'd12);
    chk("t1_zero", resp_zero, 1'b0);
    resp_ready = 2'b01;
    cyc();
    resp_ready = 2'b00;
    #2 chk("t1_idle", busy, 1'b0);

    // 2: SUB equal operands from requester 1
    set_req(1, 32'h1234, 32'h1234, 4'd1);
    req_valid = 2'b10;
    #2 chk("t2_req_ready", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    cyc();
    #2 chk("t2_resp_valid", resp_valid, 2'b10);
    chk("t2_result", resp_result, 32'd0);
    chk("t2_zero", resp_zero, 1'b1);
    resp_ready = 2'b10;
    cyc();
    resp_ready = 2'b00;

    // 3: contention after reset, then alternate
    do_reset();
    set_req(0, 32'hFFFF_FFFF, 32'd1, 4'd9);
    set_req(1, 32'hFFFF_FFFF, 32'd1, 4'd8);
    req_valid = 2'b11;
    #2 chk("t3_first_grant", req_ready, 2'b01);
    cyc();
    req_valid = 2'b10;
    #2 chk("t3_no_accept_exec", req_ready, 2'b00);
    cyc();
    cyc();
    #2 chk("t3_rv0", resp_valid, 2'b01);
    chk("t3_slt", resp_result, 32'd1);
    resp_ready = 2'b11;
    cyc();
    resp_ready = 2'b00;
    #2 chk("t3_second_grant", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    #2 chk("t3_rv1", resp_valid, 2'b10);
    chk("t3_sltu", resp_result, 32'd0);
    resp_ready = 2'b10;
    req_valid = 2'b11;
    cyc();
    resp_ready = 2'b00;
    #2 chk("t3_third_grant", req_ready, 2'b01);

    // 4: response held for 5 cycles while requester 1 waits
    cyc();
    req_valid = 2'b10;
    cyc();
    for (int k = 0; k < 5; k++) begin
      #2 chk("t4_rv_hold", resp_valid, 2'b01);
      chk("t4_result_hold", resp_result, 32'd1);
      chk("t4_zero_hold", resp_zero, 1'b0);
      chk("t4_req_ready_hold", req_ready, 2'b00);
      chk("t4_busy_hold", busy, 1'b1);
      cyc();
    end
    resp_ready = 2'b01;
    #2 chk("t4_still_blocked", req_ready, 2'b00);
    cyc();
    resp_ready = 2'b00;
    #2 chk("t4_release_grant", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    #2 chk("t4_rv1", resp_valid, 2'b10);
    chk("t4_sltu", resp_result, 32'd0);
    resp_ready = 2'b10;
    cyc();
    resp_ready = 2'b00;

    // 5: reset while an operation is in EXEC
    do_reset();
    set_req(0, 32'd100, 32'd23, 4'd0);
    set_req(1, 32'hF0F0_0000, 32'h0F0F_0000, 4'd4);
    req_valid = 2'b11;
    cyc();
    #2 chk("t5_in_exec", busy, 1'b1);
    RESET = 1'b1;
    cyc();
    #2 chk("t5_busy", busy, 1'b0);
    chk("t5_rv", resp_valid, 2'b00);
    chk("t5_rr", req_ready, 2'b00);
    chk("t5_result", resp_result, 32'd0);
    chk("t5_zero", resp_zero, 1'b0);
    chk("t5_err", resp_err, 1'b0);
    chk("t5_alu_a", alu_a, 32'd0);
    chk("t5_alu_b", alu_b, 32'd0);
    chk("t5_alu_ctrl", alu_control, 4'd0);
    RESET = 1'b0;
    #1 chk("t5_grant0", req_ready, 2'b01);
    cyc();
    req_valid = 2'b10;
    cyc();
    cyc();
    #2 chk("t5_rv0", resp_valid, 2'b01);
    chk("t5_add", resp_result, 32'd123);
    resp_ready = 2'b01;
    cyc();
    resp_ready = 2'b00;
    req_valid = 2'b00;

    // 6: illegal opcode
    do_reset();
    set_req(0, 32'd3, 32'd4, 4'd12);
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
`ifdef ALU_ARB_OPCHECK_EN
    #2 chk("t6_ctrl", alu_control, 4'd0);
`else
    #2 chk("t6_ctrl", alu_control, 4'd12);
`endif
    cyc();
`ifdef ALU_ARB_OPCHECK_EN
    #2 chk("t6_err", resp_err, 1'b1);
    chk("t6_result", resp_result, 32'd0);
    chk("t6_zero", resp_zero, 1'b1);
`else
    #2 chk("t6_err", resp_err, 1'b0);
`endif
    resp_ready = 2'b01;
    cyc();
    resp_ready = 2'b00;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      RESET = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && !acc_q[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          logic [W-1:0] a, b;
          logic [OW-1:0] op;
          a = $urandom;
          b = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 40));
          if ($urandom_range(0, 7) == 0) b = a;
          op = ($urandom_range(0, 7) == 0) ? OW'($urandom_range(10, 15)) : OW'($urandom_range(0, 9));
          set_req(i, a, b, op);
          req_valid[i] = 1'b1;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = 2'($urandom_range(0, 3));
    end

    cyc();
    RESET = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b11;
    repeat (10) cyc();
    #2 chk("drain_busy", busy, 1'b0);
    chk("drain_completed_some", (n_done > 100), 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
